// File: rtl/grant_packet_mux_pkg.sv
// Shared types and helpers for the arbiter family and its grant consumers.
package grant_packet_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so a single-requestor build still has an index bit.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/grant_packet_mux_grant_decode.sv
// Combinational one-hot to index encoder with a one-hot validity flag.
module grant_decode
  import grant_packet_mux_pkg::*;
#(
  parameter int NUM_REQUESTORS = 4,
  parameter int IDX_WIDTH      = clog2_min1(NUM_REQUESTORS)
) (
  input  logic [NUM_REQUESTORS-1:0] onehot,
  output logic [IDX_WIDTH-1:0]      index,
  output logic                      is_onehot
);

  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_REQUESTORS; i++) begin
      if (onehot[i]) index = index | IDX_WIDTH'(i);
    end
    is_onehot = (onehot != '0) &&
                ((onehot & (onehot - NUM_REQUESTORS'(1))) == '0);
  end

endmodule

// File: rtl/grant_packet_mux.sv
// Locks onto the arbiter's granted requestor and forwards its packet through
// one registered valid/ready stage, releasing once the last beat drains.
module grant_packet_mux
  import grant_packet_mux_pkg::*;
#(
  parameter  int NUM_REQUESTORS = 4,
  parameter  int DATA_WIDTH     = 32,
  parameter  int BEAT_CNT_WIDTH = 16,
  localparam int IDX_WIDTH      = clog2_min1(NUM_REQUESTORS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQUESTORS-1:0]            grant,
  input  logic                                 grant_valid,
  input  logic [NUM_REQUESTORS-1:0]            in_valid,
  input  logic [NUM_REQUESTORS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQUESTORS-1:0]            in_last,
  output logic [NUM_REQUESTORS-1:0]            in_ready,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_last,
  output logic [IDX_WIDTH-1:0]                 out_src,
  input  logic                                 out_ready,
  output logic                                 busy,
  output logic                                 pkt_done,
  output logic [BEAT_CNT_WIDTH-1:0]            pkt_beats,
  output logic                                 grant_error
);

  state_t                    state;
  state_t                    next_state;
  logic [IDX_WIDTH-1:0]      sel;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
  logic [IDX_WIDTH-1:0]      grant_idx;
  logic                      grant_onehot;
  logic                      sel_valid;
  logic                      sel_last;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      stage_free;
  logic                      accept;
  logic                      drain_last;

  grant_decode #(
    .NUM_REQUESTORS(NUM_REQUESTORS),
    .IDX_WIDTH     (IDX_WIDTH)
  ) u_grant_decode (
    .onehot   (grant),
    .index    (grant_idx),
    .is_onehot(grant_onehot)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQUESTORS; i++) begin
      if (IDX_WIDTH'(i) == sel) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
        sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign stage_free = ~out_valid | out_ready;
  assign accept     = (state == XFER) & sel_valid & stage_free;
  assign drain_last = out_valid & out_ready & out_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_valid && grant_onehot) next_state = XFER;
      XFER:    if (accept && sel_last) next_state = DRAIN;
      DRAIN:   if (drain_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // in_ready follows the registered state, so reset drops it without waiting for a clock.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_REQUESTORS; i++) begin
      in_ready[i] = (state == XFER) && (IDX_WIDTH'(i) == sel) && stage_free;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel         <= '0;
      beat_cnt    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_src     <= '0;
      pkt_done    <= 1'b0;
      pkt_beats   <= '0;
      grant_error <= 1'b0;
    end else begin
      pkt_done    <= 1'b0;
      grant_error <= 1'b0;
      if (state == IDLE && grant_valid) begin
        if (grant_onehot) begin
          sel      <= grant_idx;
          beat_cnt <= '0;
        end else begin
          grant_error <= 1'b1;
        end
      end
      // A new beat overwrites the stage even while the old one is draining.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_src   <= sel;
        if (beat_cnt != '1) beat_cnt <= beat_cnt + BEAT_CNT_WIDTH'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == DRAIN && drain_last) begin
        pkt_done  <= 1'b1;
        pkt_beats <= beat_cnt;
      end
    end
  end

endmodule

// File: tb/tb_grant_packet_mux.sv
// Directed-vector bench for grant_packet_mux with hand-computed expectations.
module tb_grant_packet_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   grant;
  logic         grant_valid;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_last;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic [1:0]   out_src;
  logic         out_ready;
  logic         busy;
  logic         pkt_done;
  logic [15:0]  pkt_beats;
  logic         grant_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grant_packet_mux dut (
    .clk        (clk),
    .reset      (reset),
    .grant      (grant),
    .grant_valid(grant_valid),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .pkt_beats  (pkt_beats),
    .grant_error(grant_error)
  );

  function automatic logic [127:0] chdata(input int ch, input logic [31:0] value);
    logic [127:0] r;
    r = '0;
    r[ch*32 +: 32] = value;
    return r;
  endfunction

  // Drives one cycle of inputs just after a rising edge, then returns at the falling edge.
  task automatic applyStimulus(input logic [3:0] g, input logic gv, input logic [3:0] iv,
                               input logic [3:0] il, input logic [127:0] d, input logic ordy);
    @(posedge clk);
    #1;
    grant       = g;
    grant_valid = gv;
    in_valid    = iv;
    in_last     = il;
    in_data     = d;
    out_ready   = ordy;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  initial begin
    reset = 1'b1; grant = '0; grant_valid = 1'b0; in_valid = '0;
    in_last = '0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_pkt_beats", 64'(pkt_beats), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single-beat packet from requestor 2
    applyStimulus(4'b0100, 1'b1, 4'b0100, 4'b0100, chdata(2, 32'hA5A5_0001), 1'b1);
    checkOutput("sb_idle_ready", 64'(in_ready), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0100, 4'b0100, chdata(2, 32'hA5A5_0001), 1'b1);
    checkOutput("sb_in_ready", 64'(in_ready), 64'b0100);
    checkOutput("sb_busy", 64'(busy), 64'd1);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("sb_out_valid", 64'(out_valid), 64'd1);
    checkOutput("sb_out_data", 64'(out_data), 64'hA5A5_0001);
    checkOutput("sb_out_src", 64'(out_src), 64'd2);
    checkOutput("sb_out_last", 64'(out_last), 64'd1);
    checkOutput("sb_drain_ready", 64'(in_ready), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("sb_pkt_done", 64'(pkt_done), 64'd1);
    checkOutput("sb_pkt_beats", 64'(pkt_beats), 64'd1);
    checkOutput("sb_busy_end", 64'(busy), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("sb_done_pulse", 64'(pkt_done), 64'd0);

    // Four-beat packet from requestor 1 with a two-cycle stall on beat 2
    applyStimulus(4'b0010, 1'b1, 4'b0000, 4'b0000, '0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 4'b0010, 4'b0000, chdata(1, 32'd1), 1'b1);
    checkOutput("bp_ready1", 64'(in_ready), 64'b0010);
    applyStimulus(4'b0000, 1'b0, 4'b0010, 4'b0000, chdata(1, 32'd2), 1'b1);
    checkOutput("bp_beat1", 64'(out_data), 64'd1);
    checkOutput("bp_ready2", 64'(in_ready), 64'b0010);
    applyStimulus(4'b0000, 1'b0, 4'b0010, 4'b0000, chdata(1, 32'd3), 1'b0);
    checkOutput("bp_beat2", 64'(out_data), 64'd2);
    checkOutput("bp_stall_ready_a", 64'(in_ready), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0010, 4'b0000, chdata(1, 32'd3), 1'b0);
    checkOutput("bp_hold_data", 64'(out_data), 64'd2);
    checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_stall_ready_b", 64'(in_ready), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0010, 4'b0000, chdata(1, 32'd3), 1'b1);
    checkOutput("bp_hold_data2", 64'(out_data), 64'd2);
    checkOutput("bp_resume_ready", 64'(in_ready), 64'b0010);
    applyStimulus(4'b0000, 1'b0, 4'b0010, 4'b0010, chdata(1, 32'd4), 1'b1);
    checkOutput("bp_beat3", 64'(out_data), 64'd3);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("bp_beat4", 64'(out_data), 64'd4);
    checkOutput("bp_last4", 64'(out_last), 64'd1);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("bp_pkt_done", 64'(pkt_done), 64'd1);
    checkOutput("bp_pkt_beats", 64'(pkt_beats), 64'd4);

    // Malformed grants in IDLE
    applyStimulus(4'b0110, 1'b1, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("bg_no_err_yet", 64'(grant_error), 64'd0);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("bg_err_multi", 64'(grant_error), 64'd1);
    checkOutput("bg_busy_a", 64'(busy), 64'd0);
    checkOutput("bg_ready_a", 64'(in_ready), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("bg_err_zero", 64'(grant_error), 64'd1);
    checkOutput("bg_busy_b", 64'(busy), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("bg_err_clear", 64'(grant_error), 64'd0);

    // Grant moves to requestor 3 while locked on requestor 0
    applyStimulus(4'b0001, 1'b1, 4'b0000, 4'b0000, '0, 1'b1);
    applyStimulus(4'b1000, 1'b1, 4'b1001, 4'b0000, chdata(0, 32'h10) | chdata(3, 32'h30), 1'b1);
    checkOutput("gc_ready_a", 64'(in_ready), 64'b0001);
    applyStimulus(4'b1000, 1'b1, 4'b1001, 4'b1001, chdata(0, 32'h11) | chdata(3, 32'h31), 1'b1);
    checkOutput("gc_data_a", 64'(out_data), 64'h10);
    checkOutput("gc_src_a", 64'(out_src), 64'd0);
    checkOutput("gc_ready_b", 64'(in_ready), 64'b0001);
    applyStimulus(4'b1000, 1'b1, 4'b1000, 4'b1000, chdata(3, 32'h32), 1'b1);
    checkOutput("gc_data_b", 64'(out_data), 64'h11);
    checkOutput("gc_src_b", 64'(out_src), 64'd0);
    checkOutput("gc_drain_ready", 64'(in_ready), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("gc_pkt_beats", 64'(pkt_beats), 64'd2);
    checkOutput("gc_busy", 64'(busy), 64'd0);

    // Back-to-back: requestor 3 granted in the pkt_done cycle of requestor 0
    applyStimulus(4'b0001, 1'b1, 4'b0000, 4'b0000, '0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 4'b0001, 4'b0000, chdata(0, 32'h100), 1'b1);
    applyStimulus(4'b0000, 1'b0, 4'b0001, 4'b0001, chdata(0, 32'h101), 1'b1);
    checkOutput("bb_data_a", 64'(out_data), 64'h100);
    applyStimulus(4'b0000, 1'b0, 4'b1000, 4'b1000, chdata(3, 32'h300), 1'b1);
    checkOutput("bb_data_b", 64'(out_data), 64'h101);
    checkOutput("bb_drain_ready", 64'(in_ready), 64'd0);
    applyStimulus(4'b1000, 1'b1, 4'b1000, 4'b1000, chdata(3, 32'h300), 1'b1);
    checkOutput("bb_pkt_done", 64'(pkt_done), 64'd1);
    checkOutput("bb_idle_ready", 64'(in_ready), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b1000, 4'b1000, chdata(3, 32'h300), 1'b1);
    checkOutput("bb_ready3", 64'(in_ready), 64'b1000);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("bb_src3", 64'(out_src), 64'd3);
    checkOutput("bb_data3", 64'(out_data), 64'h300);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("bb_pkt_beats", 64'(pkt_beats), 64'd1);

    // Reset while beat 3 of a five-beat packet is being offered
    applyStimulus(4'b0100, 1'b1, 4'b0000, 4'b0000, '0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 4'b0100, 4'b0000, chdata(2, 32'h501), 1'b1);
    applyStimulus(4'b0000, 1'b0, 4'b0100, 4'b0000, chdata(2, 32'h502), 1'b1);
    applyStimulus(4'b0000, 1'b0, 4'b0100, 4'b0000, chdata(2, 32'h503), 1'b1);
    checkOutput("mr_before", 64'(out_data), 64'h502);
    #1 reset = 1'b1;
    #1;
    checkOutput("mr_in_ready", 64'(in_ready), 64'd0);
    checkOutput("mr_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mr_out_data", 64'(out_data), 64'd0);
    checkOutput("mr_busy", 64'(busy), 64'd0);
    checkOutput("mr_pkt_beats", 64'(pkt_beats), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0100, 4'b0000, chdata(2, 32'h503), 1'b1);
    checkOutput("mr_no_done_a", 64'(pkt_done), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("mr_no_done_b", 64'(pkt_done), 64'd0);
    reset = 1'b0;
    applyStimulus(4'b0010, 1'b1, 4'b0010, 4'b0010, chdata(1, 32'h777), 1'b1);
    checkOutput("mr_no_done_c", 64'(pkt_done), 64'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0010, 4'b0010, chdata(1, 32'h777), 1'b1);
    checkOutput("mr_fresh_ready", 64'(in_ready), 64'b0010);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("mr_fresh_data", 64'(out_data), 64'h777);
    checkOutput("mr_fresh_src", 64'(out_src), 64'd1);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    checkOutput("mr_fresh_done", 64'(pkt_done), 64'd1);
    checkOutput("mr_fresh_beats", 64'(pkt_beats), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
